// File: rtl/fc_class_sequencer_pkg.sv
// Shared constants and FSM encoding for the final-layer class sequencer.
// Defaults describe the 10-class CNN head with a 4-stage dot-product pipeline.
package fc_class_sequencer_pkg;

  localparam int DEF_OUT_DW    = 8;
  localparam int DEF_SCORE_W   = DEF_OUT_DW + 1;
  localparam int DEF_NUM_CLASS = 10;
  localparam int DEF_IDX_W     = 4;
  localparam int DEF_PIPE_LAT  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/fc_class_sequencer_valid_delay_line.sv
// DEPTH-stage shift register carrying {valid, idx} alongside the dot-product
// pipeline so each returning score can be tagged with its class index.
module valid_delay_line
  import fc_class_sequencer_pkg::*;
#(
  parameter int DEPTH = DEF_PIPE_LAT,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [DEPTH-1:0] valid_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        idx_q[i]   <= {IDX_W{1'b0}};
      end
    end else begin
      valid_q[0] <= valid_i;
      idx_q[0]   <= idx_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign idx_o   = idx_q[DEPTH-1];

endmodule

// File: rtl/fc_class_sequencer.sv
// Steps the class index through the last FC layer, realigns returning scores
// with their class and reports the argmax with a one-cycle done pulse.
module fc_class_sequencer
  import fc_class_sequencer_pkg::*;
#(
  parameter int OUT_DW    = DEF_OUT_DW,
  parameter int NUM_CLASS = DEF_NUM_CLASS,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int PIPE_LAT  = DEF_PIPE_LAT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic [IDX_W-1:0]         weight_sel_o,
  output logic                     issue_valid_o,
  input  logic signed [OUT_DW:0]   score_in_i,
  output logic [IDX_W-1:0]         class_out_o,
  output logic signed [OUT_DW:0]   max_score_o,
  output logic                     done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  fsm_state_e state_q, state_d;
  logic [IDX_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]       weight_sel_q, weight_sel_d;
  logic                   done_q, done_d;
  logic signed [OUT_DW:0] run_max_q, run_max_d;
  logic [IDX_W-1:0]       run_idx_q, run_idx_d;
  logic signed [OUT_DW:0] max_score_q, max_score_d;
  logic [IDX_W-1:0]       class_out_q, class_out_d;
  logic                   ret_valid_s;
  logic [IDX_W-1:0]       ret_idx_s;
  logic                   finish_s;

  valid_delay_line #(
    .DEPTH (PIPE_LAT),
    .IDX_W (IDX_W)
  ) u_ret_align (
    .clk     (clk),
    .clr_i   (reset),
    .valid_i (issue_valid_q),
    .idx_i   (weight_sel_q),
    .valid_o (ret_valid_s),
    .idx_o   (ret_idx_s)
  );

  // Sequencer FSM next state; issue outputs are derived from the next state
  // so they can be registered and still line up with the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ISSUE;
          cnt_d   = ZERO_IDX;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DRAIN;
          cnt_d   = ZERO_IDX;
        end else begin
          cnt_d   = cnt_q + ONE_IDX;
        end
      end
      ST_DRAIN: begin
        if (ret_valid_s && (ret_idx_s == LAST_IDX)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (start_i) begin
          state_d = ST_ISSUE;
          cnt_d   = ZERO_IDX;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = ZERO_IDX;
      end
    endcase

    issue_valid_d = (state_d == ST_ISSUE);
    if (issue_valid_d) begin
      weight_sel_d = cnt_d;
    end else begin
      weight_sel_d = ZERO_IDX;
    end
    busy_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  assign finish_s = (state_q == ST_DRAIN) && (state_d == ST_DONE);

  // Running argmax: class 0 always loads, later classes need a strict win
  // so ties keep the lower index. Result capture sees the final update.
  always_comb begin
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    max_score_d = max_score_q;
    class_out_d = class_out_q;
    if (ret_valid_s) begin
      if ((ret_idx_s == ZERO_IDX) || (score_in_i > run_max_q)) begin
        run_max_d = score_in_i;
        run_idx_d = ret_idx_s;
      end else begin
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
      end
    end else begin
      run_max_d = run_max_q;
      run_idx_d = run_idx_q;
    end
    if (finish_s) begin
      max_score_d = run_max_d;
      class_out_d = run_idx_d;
    end else begin
      max_score_d = max_score_q;
      class_out_d = class_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= ZERO_IDX;
      busy_q        <= 1'b0;
      issue_valid_q <= 1'b0;
      weight_sel_q  <= ZERO_IDX;
      done_q        <= 1'b0;
      run_max_q     <= {(OUT_DW+1){1'b0}};
      run_idx_q     <= ZERO_IDX;
      max_score_q   <= {(OUT_DW+1){1'b0}};
      class_out_q   <= ZERO_IDX;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      issue_valid_q <= issue_valid_d;
      weight_sel_q  <= weight_sel_d;
      done_q        <= done_d;
      run_max_q     <= run_max_d;
      run_idx_q     <= run_idx_d;
      max_score_q   <= max_score_d;
      class_out_q   <= class_out_d;
    end
  end

  assign busy_o        = busy_q;
  assign issue_valid_o = issue_valid_q;
  assign weight_sel_o  = weight_sel_q;
  assign done_o        = done_q;
  assign max_score_o   = max_score_q;
  assign class_out_o   = class_out_q;

endmodule

// File: tb/tb_fc_class_sequencer.sv
// Directed bench for fc_class_sequencer: scores are driven on the cycles the
// 4-stage pipeline would return them, with off-window garbage to catch skew.
module tb_fc_class_sequencer;

  localparam int OUT_DW    = 8;
  localparam int NUM_CLASS = 10;
  localparam int IDX_W     = 4;
  localparam int PIPE_LAT  = 4;
  localparam logic signed [OUT_DW:0] GARBAGE = 9'sd100;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic signed [OUT_DW:0] score_in;
  logic                   busy;
  logic [IDX_W-1:0]       weight_sel;
  logic                   issue_valid;
  logic [IDX_W-1:0]       class_out;
  logic signed [OUT_DW:0] max_score;
  logic                   done;

  logic signed [OUT_DW:0] scores [NUM_CLASS];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fc_class_sequencer #(
    .OUT_DW    (OUT_DW),
    .NUM_CLASS (NUM_CLASS),
    .IDX_W     (IDX_W),
    .PIPE_LAT  (PIPE_LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start),
    .busy_o        (busy),
    .weight_sel_o  (weight_sel),
    .issue_valid_o (issue_valid),
    .score_in_i    (score_in),
    .class_out_o   (class_out),
    .max_score_o   (max_score),
    .done_o        (done)
  );

  // Score for cycle T+j after the start edge: class j-1-PIPE_LAT inside the window.
  task automatic drive_score(input int j);
    if (j >= PIPE_LAT + 1 && j <= PIPE_LAT + NUM_CLASS) score_in = scores[j-PIPE_LAT-1];
    else score_in = GARBAGE;
  endtask

  // Starts a run from a negedge and returns at the negedge of the done cycle.
  task automatic run_to_done(input bit poke, output int lat);
    lat = -1;
    start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      start = (poke && (j == 3 || j == 12)) ? 1'b1 : 1'b0;
      if (done) begin
        lat = j;
        start = 1'b0;
        break;
      end
      drive_score(j);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; score_in = GARBAGE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid got %b want 0", issue_valid); end
    n_checks++; if (weight_sel !== 4'd0) begin n_fail++; $display("FAIL reset_weight_sel got %0d want 0", weight_sel); end
    n_checks++; if (class_out !== 4'd0) begin n_fail++; $display("FAIL reset_class_out got %0d want 0", class_out); end
    n_checks++; if (max_score !== 9'sd0) begin n_fail++; $display("FAIL reset_max_score got %0d want 0", max_score); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_issue_seq();
    logic             exp_iv;
    logic [IDX_W-1:0] exp_ws;
    for (int i = 0; i < NUM_CLASS; i++) scores[i] = 9'(i);
    @(negedge clk);
    n_checks++; if (issue_valid !== 1'b0 || weight_sel !== 4'd0) begin
      n_fail++; $display("FAIL seq_idle got iv=%b ws=%0d want iv=0 ws=0", issue_valid, weight_sel);
    end
    start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      start = 1'b0;
      drive_score(j);
      exp_iv = (j <= NUM_CLASS);
      exp_ws = exp_iv ? IDX_W'(j - 1) : 4'd0;
      n_checks++; if (issue_valid !== exp_iv) begin
        n_fail++; $display("FAIL seq_issue_valid cycle T+%0d got %b want %b", j, issue_valid, exp_iv);
      end
      n_checks++; if (weight_sel !== exp_ws) begin
        n_fail++; $display("FAIL seq_weight_sel cycle T+%0d got %0d want %0d", j, weight_sel, exp_ws);
      end
      n_checks++; if (busy !== (j <= 14)) begin
        n_fail++; $display("FAIL seq_busy cycle T+%0d got %b want %b", j, busy, (j <= 14));
      end
      n_checks++; if (done !== (j == 15)) begin
        n_fail++; $display("FAIL seq_done cycle T+%0d got %b want %b", j, done, (j == 15));
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    scores = '{9'sd3, -9'sd5, 9'sd20, 9'sd7, 9'sd20, -9'sd128, 9'sd0, 9'sd1, 9'sd19, -9'sd1};
    run_to_done(1'b0, lat);
    n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL basic_latency got %0d want 15", lat); end
    n_checks++; if (class_out !== 4'd2) begin n_fail++; $display("FAIL basic_class got %0d want 2", class_out); end
    n_checks++; if (max_score !== 9'sd20) begin n_fail++; $display("FAIL basic_max got %0d want 20", max_score); end
  endtask

  task automatic test_all_negative();
    int lat;
    scores = '{-9'sd1, -9'sd2, -9'sd3, -9'sd4, -9'sd5, -9'sd6, -9'sd7, -9'sd8, -9'sd9, -9'sd10};
    @(negedge clk);
    run_to_done(1'b0, lat);
    n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL neg_latency got %0d want 15", lat); end
    n_checks++; if (class_out !== 4'd0) begin n_fail++; $display("FAIL neg_class got %0d want 0", class_out); end
    n_checks++; if (max_score !== -9'sd1) begin n_fail++; $display("FAIL neg_max got %0d want -1", max_score); end
  endtask

  task automatic test_extremes();
    int lat;
    for (int i = 0; i < NUM_CLASS - 1; i++) scores[i] = 9'sh100;
    scores[NUM_CLASS-1] = 9'sd255;
    @(negedge clk);
    run_to_done(1'b0, lat);
    n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL ext_latency got %0d want 15", lat); end
    n_checks++; if (class_out !== 4'd9) begin n_fail++; $display("FAIL ext_class got %0d want 9", class_out); end
    n_checks++; if (max_score !== 9'sd255) begin n_fail++; $display("FAIL ext_max got %0d want 255", max_score); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ext_done_pulse got %b want 0", done); end
    n_checks++; if (class_out !== 4'd9 || max_score !== 9'sd255) begin
      n_fail++; $display("FAIL ext_hold got %0d/%0d want 9/255", class_out, max_score);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    scores = '{9'sd3, -9'sd5, 9'sd20, 9'sd7, 9'sd20, -9'sd128, 9'sd0, 9'sd1, 9'sd19, -9'sd1};
    @(negedge clk);
    run_to_done(1'b0, lat);
    n_checks++; if (lat !== 15 || class_out !== 4'd2) begin
      n_fail++; $display("FAIL b2b_first got lat=%0d cls=%0d want lat=15 cls=2", lat, class_out);
    end
    for (int i = 0; i < NUM_CLASS - 1; i++) scores[i] = 9'sh100;
    scores[NUM_CLASS-1] = 9'sd255;
    run_to_done(1'b1, lat);
    n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 15", lat); end
    n_checks++; if (class_out !== 4'd9 || max_score !== 9'sd255) begin
      n_fail++; $display("FAIL b2b_second_result got %0d/%0d want 9/255", class_out, max_score);
    end
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL b2b_no_queue cycle +%0d got busy=%b done=%b want 0/0", j, busy, done);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < NUM_CLASS; i++) scores[i] = 9'(i * 3);
    start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      start = 1'b0;
      drive_score(j);
      if (j == 2) begin
        n_checks++; if (class_out !== 4'd9 || max_score !== 9'sd255) begin
          n_fail++; $display("FAIL mid_hold_prev got %0d/%0d want 9/255", class_out, max_score);
        end
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0 || issue_valid !== 1'b0 || weight_sel !== 4'd0) begin
      n_fail++; $display("FAIL mid_reset_ctrl got busy=%b iv=%b ws=%0d want 0/0/0", busy, issue_valid, weight_sel);
    end
    n_checks++; if (class_out !== 4'd0 || max_score !== 9'sd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_result got cls=%0d max=%0d done=%b want 0/0/0", class_out, max_score, done);
    end
    for (int i = 0; i < 10; i++) begin
      score_in = 9'(40 + 20 * i);
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || class_out !== 4'd0 || max_score !== 9'sd0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL mid_garbage cycle %0d got done=%b cls=%0d max=%0d busy=%b want 0/0/0/0",
                           i, done, class_out, max_score, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_issue_seq();
    test_basic();
    test_all_negative();
    test_extremes();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
